// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div HI/LO sequencer: request op codes,
// ALU select constants, controller state and the operand payload.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  localparam logic [3:0] ALU_S_MUL  = 4'd3;
  localparam logic [3:0] ALU_S_DIV  = 4'd4;
  localparam logic [3:0] ALU_S_IDLE = 4'd13;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
  } operand_t;

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// Sequencer for the multicycle mult/div ALU paths: holds operands stable for a
// fixed number of cycles, then captures Result/Result2 into HI/LO.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_x,
  input  logic [XLEN-1:0] req_y,
  output logic            req_ready,
  input  logic            flush,
  input  logic            rd_hilo,
  output logic            hilo_stall,
  output logic [3:0]      alu_s,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_result2,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done,
  output logic            div_zero
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  operand_t         opnd;
  logic             accept;

  assign req_ready  = (state == IDLE) && !flush;
  assign hilo_stall = rd_hilo && (state == RUN);
  assign accept     = req_valid && req_ready;
  assign alu_x      = opnd.x;
  assign alu_y      = opnd.y;

  // Control FSM; operands and select stay frozen for the whole RUN window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opnd     <= '0;
      alu_s    <= ALU_S_IDLE;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MTHI: hi <= req_x;
              OP_MTLO: lo <= req_x;
              OP_MULT: begin
                opnd  <= '{x: req_x, y: req_y};
                alu_s <= ALU_S_MUL;
                cnt   <= CNT_W'(MUL_CYCLES - 1);
                state <= RUN;
              end
              default: begin
                if (req_y == '0) begin
                  div_zero <= 1'b1;
                end else begin
                  opnd  <= '{x: req_x, y: req_y};
                  alu_s <= ALU_S_DIV;
                  cnt   <= CNT_W'(DIV_CYCLES - 1);
                  state <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          // Flush beats completion, even on the final edge.
          if (flush) begin
            state <= IDLE;
            alu_s <= ALU_S_IDLE;
          end else if (cnt == '0) begin
            lo    <= alu_result;
            hi    <= alu_result2;
            done  <= 1'b1;
            state <= IDLE;
            alu_s <= ALU_S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed vector table plus randomized traffic,
// checked against a transaction-level model of the HI/LO sequencer.
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned MULN = 4;
  localparam int unsigned DIVN = 8;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, flush, rd_hilo, hilo_stall, done, div_zero;
  logic [1:0]  req_op;
  logic [31:0] req_x, req_y, alu_x, alu_y, alu_result, alu_result2, hi, lo;
  logic [3:0]  alu_s;
  logic [63:0] prod;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_ready(req_ready), .flush(flush),
    .rd_hilo(rd_hilo), .hilo_stall(hilo_stall), .alu_s(alu_s), .alu_x(alu_x),
    .alu_y(alu_y), .alu_result(alu_result), .alu_result2(alu_result2),
    .hi(hi), .lo(lo), .done(done), .div_zero(div_zero)
  );

  // Stand-in for the parent's ALU: unsigned product / quotient+remainder.
  always_comb begin
    prod        = '0;
    alu_result  = '0;
    alu_result2 = '0;
    case (alu_s)
      4'd3: begin
        prod        = 64'(alu_x) * 64'(alu_y);
        alu_result  = prod[31:0];
        alu_result2 = prod[63:32];
      end
      4'd4: if (alu_y != 0) begin
        alu_result  = alu_x / alu_y;
        alu_result2 = alu_x % alu_y;
      end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: remaining edges until the pending result lands.
  bit          m_busy, m_isdiv, m_done, m_dz;
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo, m_x, m_y;

  task automatic model_reset();
    m_busy = 0; m_isdiv = 0; m_done = 0; m_dz = 0; m_rem = 0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_x = 0; m_y = 0;
  endtask

  task automatic model_step();
    logic [63:0] p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    m_dz   = 0;
    if (m_busy) begin
      if (flush) m_busy = 0;
      else if (m_rem == 1) begin
        m_hi = m_phi; m_lo = m_plo; m_done = 1; m_busy = 0;
      end else m_rem--;
    end else if (req_valid && !flush) begin
      case (req_op)
        2'd2: m_hi = req_x;
        2'd3: m_lo = req_x;
        2'd0: begin
          p = 64'(req_x) * 64'(req_y);
          m_phi = p[63:32]; m_plo = p[31:0];
          m_x = req_x; m_y = req_y; m_isdiv = 0; m_busy = 1; m_rem = MULN;
        end
        default: begin
          if (req_y == 0) m_dz = 1;
          else begin
            m_phi = req_x % req_y; m_plo = req_x / req_y;
            m_x = req_x; m_y = req_y; m_isdiv = 1; m_busy = 1; m_rem = DIVN;
          end
        end
      endcase
    end
  endtask

  // One cycle: drive, check mid-cycle against the model, clock, advance model.
  task automatic apply(input logic r, input logic v, input logic [1:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic f, input logic rd);
    rst_n = r; req_valid = v; req_op = op; req_x = x; req_y = y; flush = f; rd_hilo = rd;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(!m_busy && !flush));
    chk("hilo_stall", 64'(hilo_stall), 64'(rd_hilo && m_busy));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("done", 64'(done), 64'(m_done));
    chk("div_zero", 64'(div_zero), 64'(m_dz));
    chk("alu_s", 64'(alu_s), m_busy ? (m_isdiv ? 64'd4 : 64'd3) : 64'd13);
    if (m_busy) begin
      chk("alu_x", 64'(alu_x), 64'(m_x));
      chk("alu_y", 64'(alu_y), 64'(m_y));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        r, v, f, rd;
    logic [1:0]  op;
    logic [31:0] x, y, ehi, elo;
    logic        edone, edz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [1:0] op,
                     input logic [31:0] x, input logic [31:0] y, input logic f,
                     input logic rd, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edone, input logic edz);
    vec_t e;
    e.r = r; e.v = v; e.op = op; e.x = x; e.y = y; e.f = f; e.rd = rd;
    e.ehi = ehi; e.elo = elo; e.edone = edone; e.edz = edz;
    vecs.push_back(e);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_op = 0; req_x = 0; req_y = 0; flush = 0; rd_hilo = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    //  r  v  op  x             y             f  rd  hi            lo            dn dz
    add(0, 0, 0, 0,            0,            0, 0, 0,            0,            0, 0);
    add(1, 1, 2, 32'h12345678, 0,            0, 1, 32'h12345678, 0,            0, 0);
    add(1, 1, 3, 32'h9ABCDEF0, 0,            0, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    add(1, 1, 2, 32'hAAAAAAAA, 0,            0, 0, 32'hAAAAAAAA, 32'h9ABCDEF0, 0, 0);
    add(1, 1, 3, 32'h55555555, 0,            0, 0, 32'hAAAAAAAA, 32'h55555555, 0, 0);
    add(1, 1, 1, 5,            0,            0, 0, 32'hAAAAAAAA, 32'h55555555, 0, 1);
    add(1, 0, 0, 0,            0,            0, 0, 32'hAAAAAAAA, 32'h55555555, 0, 0);
    add(1, 1, 0, 32'h00010000, 32'h00010000, 0, 1, 32'hAAAAAAAA, 32'h55555555, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 0, 0, 0, 1, 32'hAAAAAAAA, 32'h55555555, 0, 0);
    add(1, 0, 0, 0,            0,            0, 1, 32'h1,        32'h0,        1, 0);
    add(1, 0, 0, 0,            0,            0, 1, 32'h1,        32'h0,        0, 0);
    add(1, 1, 1, 100,          7,            0, 1, 32'h1,        32'h0,        0, 0);
    for (int i = 0; i < 7; i++)
      add(1, 1, 2'(i), 32'hFFFF0000 + 32'(i), 32'(i), 0, 1, 32'h1, 32'h0, 0, 0);
    add(1, 0, 0, 0,            0,            0, 1, 32'd2,        32'd14,       1, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 1, 0, 3,            4,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            1, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 1, 0, 3,            4,            0, 0, 32'd2,        32'd14,       0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 0, 0, 0, 0, 32'd2, 32'd14, 0, 0);
    add(1, 0, 0, 0,            0,            1, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 1, 2, 32'hDEAD,     0,            1, 0, 32'd2,        32'd14,       0, 0);
    add(1, 1, 1, 100,          7,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 32'd2,        32'd14,       0, 0);
    add(0, 0, 0, 0,            0,            0, 0, 0,            0,            0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 0,            0,            0, 0);
    add(1, 1, 0, 6,            7,            0, 0, 0,            0,            0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 2,            3,            0, 0, 0,            32'd42,       1, 0);
    add(1, 1, 0, 2,            3,            0, 0, 0,            32'd42,       0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 0, 0, 0, 0, 0, 32'd42, 0, 0);
    add(1, 0, 0, 0,            0,            0, 0, 0,            32'd6,        1, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].rd);
      chk("tbl_hi", 64'(hi), 64'(vecs[i].ehi));
      chk("tbl_lo", 64'(lo), 64'(vecs[i].elo));
      chk("tbl_done", 64'(done), 64'(vecs[i].edone));
      chk("tbl_div_zero", 64'(div_zero), 64'(vecs[i].edz));
    end

    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 1) == 1),
            2'($urandom_range(0, 3)),
            $urandom(),
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Multi-cycle sequencer for the mult/div paths of a dedicated ALU instance. Those paths are timed as multicycle paths and are not single-cycle safe.
- Accepts mult/div/mthi/mtlo requests from decode and latches the operands. It holds them stable on the ALU inputs for a programmable number of cycles, then captures Result/Result2 into architectural HI/LO.
- Provides a stall to the pipeline for mfhi/mflo while an operation is in flight.

Parameters:
- MUL_CYCLES, 4, cycles operands are held before the product is captured; must be >= 1.
- DIV_CYCLES, 8, cycles operands are held before quotient/remainder are captured; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_op  in  2  operation: 0 MULT, 1 DIV, 2 MTHI, 3 MTLO.
- req_x  in  32  operand X; also the data for MTHI/MTLO.
- req_y  in  32  operand Y.
- req_ready  out  1  controller can accept a request.
- flush  in  1  pipeline flush (exception); cancels any in-flight op.
- rd_hilo  in  1  decode is issuing mfhi/mflo this cycle.
- hilo_stall  out  1  stall decode.
- alu_s  out  4  ALU op select.
- alu_x  out  32  ALU X input.
- alu_y  out  32  ALU Y input.
- alu_result  in  32  ALU Result (product lower / quotient).
- alu_result2  in  32  ALU Result2 (product upper / remainder).
- hi  out  32  HI register.
- lo  out  32  LO register.
- done  out  1  one-cycle pulse when a mult/div has updated HI/LO.
- div_zero  out  1  one-cycle pulse when a DIV with Y==0 is rejected.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State IDLE, counter 0.
  - hi=0, lo=0, done=0, div_zero=0.
  - Operand registers 0; alu_s=13 (constant-zero select).
  - Reset mid-operation abandons the op; HI/LO return to 0.
- States: IDLE, RUN.
- req_ready = (state==IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready.
- Accept in IDLE:
  - MTHI: hi<=req_x at that edge. Stay IDLE; no done pulse.
  - MTLO: lo<=req_x at that edge. Stay IDLE; no done pulse.
  - MULT: latch X/Y, alu_s<=3, cnt<=MUL_CYCLES-1, go to RUN.
  - DIV with req_y!=0: latch X/Y, alu_s<=4, cnt<=DIV_CYCLES-1, go to RUN.
  - DIV with req_y==0: stay IDLE, HI/LO unchanged, div_zero=1 for the next cycle.
- In RUN:
  - alu_x/alu_y/alu_s are registered and must not change.
  - While cnt!=0: cnt decrements each edge.
  - At the edge with cnt==0: lo<=alu_result, hi<=alu_result2, state<=IDLE, alu_s<=13.
  - done=1 for exactly the following cycle; req_ready is high in that same cycle.
- Latency: request accepted at edge E0 gives HI/LO written at edge E0+N, where N=MUL_CYCLES or DIV_CYCLES. The controller is busy for cycles 1..N; back-to-back issue is possible at edge E0+N+1.
- Flush:
  - In RUN: state<=IDLE at the next edge, HI/LO not written, no done, alu_s<=13.
  - Flush together with req_valid in IDLE: request dropped, since req_ready=0.
  - Flush on the final RUN edge (cnt==0): flush wins and HI/LO are not written.
- hilo_stall = rd_hilo && (state==RUN). It is combinational and low in the done cycle, so mfhi/mflo in that cycle read the new value.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)). There is no wrap; the counter never decrements below 0.
- req_op and req_x/req_y are ignored when the request is not accepted.

Decomposition:
- Shared package muldiv_pkg holds:
  - op codes OP_MULT=0, OP_DIV=1, OP_MTHI=2, OP_MTLO=3;
  - ALU select constants ALU_S_MUL=4'd3, ALU_S_DIV=4'd4, ALU_S_IDLE=4'd13;
  - a state enum {IDLE, RUN}.
- No sub-module is required. The controller is a single FSM with a counter. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- MULT: X=0x0001_0000, Y=0x0001_0000 -> hilo_stall asserted with rd_hilo during 4 busy cycles; hi=0x0000_0001, lo=0x0000_0000 on edge E0+4; done pulses once.
- DIV: X=100, Y=7 -> lo=14, hi=2 after exactly 8 cycles. alu_x/alu_y are held at 100/7 throughout RUN even if req_x/req_y toggle.
- DIV by zero: X=5, Y=0 with hi=0xAAAA_AAAA, lo=0x5555_5555 preloaded -> div_zero pulses for 1 cycle; hi/lo unchanged; req_ready stays high.
- Flush mid-op: MULT 3*4, flush on busy cycle 2 -> back to IDLE next edge; hi/lo keep their prior values; no done. Repeat with flush on the last busy edge and get the same result.
- MTHI then MTLO: MTHI 0x1234_5678 followed next cycle by MTLO 0x9ABC_DEF0 -> hi/lo updated on consecutive edges; rd_hilo never stalls.
- Reset asserted during DIV RUN -> next cycle hi=lo=0, req_ready=1, alu_s=13, done=0.
